ws2812_frame_arb: RTL and testbench

- Shares the single WS2812 serial driver (ws2812_ctrl) between two pixel-frame sources.
  - Source A is the key/colour draw path.
  - Source B is a pattern/test generator.
- Arbitrates round-robin between refresh requests and issues ws2812_start.
- Answers each cfg_start pixel request with cfg_num/cfg_data fetched from the granted source.
- Enforces the WS2812 latch/reset gap before the next frame.
- Sits between the frame sources and ws2812_ctrl.

---
 rtl/ws2812_frame_arb.sv | 216 +++++++++++++++++++++
 tb/tb_ws2812_frame_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_arb.sv
// ws2812_frame_arb: shares one WS2812 serial driver between two pixel-frame sources.
// Round-robin arbitration of frame-refresh requests. Each cfg_start pixel request is
// answered from the granted source one clock later. The WS2812 latch gap is enforced
// before the next frame.
//
// Build option: define WS_WDOG_EN to add a FEED/DRAIN watchdog that aborts a stalled
// frame and pulses wdog_err. Without it, wdog_err is tied low.
//
// Ports:
//   sys_clk, sys_rst        clock; synchronous active-high reset
//   req_a, req_b            level frame-refresh requests (A = draw path, B = pattern gen)
//   gnt_a, gnt_b            ownership of the current frame
//   pix_idx                 pixel index presented to the granted source
//   pix_data_a, pix_data_b  {G,R,B} pixel from each source, combinational from pix_idx
//   ws2812_start            one-cycle frame start to ws2812_ctrl
//   cfg_start               pixel request pulse from ws2812_ctrl
//   cfg_num, cfg_data       served pixel index/data, held until the next request
//   tx_done                 last bit shifted out by ws2812_ctrl
//   busy                    high in every state except IDLE
//   wdog_err                one-cycle watchdog abort pulse
module ws2812_frame_arb #(
    parameter int unsigned NUM_LED  = 64,
    parameter int unsigned LED_W    = 6,
    parameter int unsigned GAP_CYC  = 15000,
    parameter int unsigned WDOG_CYC = 2000000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             req_a,
    input  logic             req_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [LED_W-1:0] pix_idx,
    input  logic [23:0]      pix_data_a,
    input  logic [23:0]      pix_data_b,
    output logic             ws2812_start,
    input  logic             cfg_start,
    output logic [LED_W-1:0] cfg_num,
    output logic [23:0]      cfg_data,
    input  logic             tx_done,
    output logic             busy,
    output logic             wdog_err
);

    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [LED_W-1:0] LAST_IDX = LED_W'(NUM_LED - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_START,
        S_FEED,
        S_DRAIN,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic               last_b_q, last_b_d;     // 1: previous grant went to B
    logic               gnt_a_q, gnt_a_d;
    logic               gnt_b_q, gnt_b_d;
    logic [LED_W-1:0]   pix_idx_q, pix_idx_d;
    logic               start_q, start_d;
    logic [LED_W-1:0]   cfg_num_q, cfg_num_d;
    logic [23:0]        cfg_data_q, cfg_data_d;
    logic               busy_q, busy_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               grant_b;

`ifdef WS_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

    logic [WDOG_W-1:0]  wdog_cnt_q, wdog_cnt_d;
    logic               wdog_err_q, wdog_err_d;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        gnt_a_d    = gnt_a_q;
        gnt_b_d    = gnt_b_q;
        pix_idx_d  = pix_idx_q;
        start_d    = 1'b0;
        cfg_num_d  = cfg_num_q;
        cfg_data_d = cfg_data_q;
        gap_cnt_d  = '0;
        // On a tie the source that did not own the last frame wins
        grant_b    = req_b && (!req_a || !last_b_q);

        case (state_q)
            S_IDLE: begin
                if (req_a || req_b) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (!req_a && !req_b) begin
                    state_d = S_IDLE;
                end else begin
                    gnt_a_d   = !grant_b;
                    gnt_b_d   = grant_b;
                    last_b_d  = grant_b;
                    pix_idx_d = '0;
                    start_d   = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                state_d = S_FEED;
            end
            S_FEED: begin
                if (cfg_start) begin
                    cfg_num_d  = pix_idx_q;
                    cfg_data_d = gnt_b_q ? pix_data_b : pix_data_a;
                    // The last pixel parks the index instead of wrapping
                    if (pix_idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end else begin
                        pix_idx_d = pix_idx_q + LED_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (tx_done) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gnt_a_d = 1'b0;
                    gnt_b_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef WS_WDOG_EN
        // Stall timer: restarts on every sign of life from ws2812_ctrl
        wdog_cnt_d = '0;
        wdog_err_d = 1'b0;
        if ((state_q == S_FEED) || (state_q == S_DRAIN)) begin
            if (cfg_start || tx_done) begin
                wdog_cnt_d = '0;
            end else if (wdog_cnt_q == WDOG_LAST) begin
                wdog_err_d = 1'b1;
                state_d    = S_GAP;
            end else begin
                wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
            end
        end
`endif

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            last_b_q   <= 1'b1;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            pix_idx_q  <= '0;
            start_q    <= 1'b0;
            cfg_num_q  <= '0;
            cfg_data_q <= '0;
            busy_q     <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            pix_idx_q  <= pix_idx_d;
            start_q    <= start_d;
            cfg_num_q  <= cfg_num_d;
            cfg_data_q <= cfg_data_d;
            busy_q     <= busy_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

`ifdef WS_WDOG_EN
    // Watchdog registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    // WDOG_CYC only matters when the watchdog is built in
    assign wdog_err = 1'b0 && (WDOG_CYC == 0);
`endif

    assign gnt_a        = gnt_a_q;
    assign gnt_b        = gnt_b_q;
    assign pix_idx      = pix_idx_q;
    assign ws2812_start = start_q;
    assign cfg_num      = cfg_num_q;
    assign cfg_data     = cfg_data_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ws2812_frame_arb.sv
// Self-checking bench for ws2812_frame_arb: stimulus pushes expected pixels/grants into
// queues, a negedge monitor pops and compares whenever the DUT presents a result.
module tb_ws2812_frame_arb;

    localparam int unsigned NUM_LED = 64;
    localparam int unsigned LED_W   = 6;
    localparam int unsigned GAP_CYC = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_a, req_b;
    logic             gnt_a, gnt_b;
    logic [LED_W-1:0] pix_idx;
    logic [23:0]      pix_data_a, pix_data_b;
    logic             ws_start;
    logic             cfg_start;
    logic [LED_W-1:0] cfg_num;
    logic [23:0]      cfg_data;
    logic             tx_done;
    logic             busy;
    logic             wdog_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_starts = 0;
    bit overlap_seen = 1'b0;
    bit wdog_seen    = 1'b0;
    bit pix_pend     = 1'b0;

    logic [29:0] exp_pix[$];   // {cfg_num, cfg_data}
    bit          exp_gnt[$];   // 1: source B expected

    always #5 clk = ~clk;

    ws2812_frame_arb #(
        .NUM_LED (NUM_LED),
        .LED_W   (LED_W),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .sys_clk      (clk),
        .sys_rst      (rst),
        .req_a        (req_a),
        .req_b        (req_b),
        .gnt_a        (gnt_a),
        .gnt_b        (gnt_b),
        .pix_idx      (pix_idx),
        .pix_data_a   (pix_data_a),
        .pix_data_b   (pix_data_b),
        .ws2812_start (ws_start),
        .cfg_start    (cfg_start),
        .cfg_num      (cfg_num),
        .cfg_data     (cfg_data),
        .tx_done      (tx_done),
        .busy         (busy),
        .wdog_err     (wdog_err)
    );

    function automatic logic [23:0] pat_a(input logic [5:0] i);
        return {2'b10, i, ~i, 2'b01, i ^ 6'h2A, 2'b11};
    endfunction

    function automatic logic [23:0] pat_b(input logic [5:0] i);
        return {i, 2'b00, 8'hC3 ^ {2'b00, i}, ~i, 2'b10};
    endfunction

    assign pix_data_a = pat_a(pix_idx);
    assign pix_data_b = pat_b(pix_idx);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: pixel results one clock after cfg_start, grants on each start pulse
    always @(negedge clk) begin
        logic [29:0] e;
        bit          g;
        if (pix_pend) begin
            if (exp_pix.size() == 0) begin
                chk("pix_unexpected", 1, 0);
            end else begin
                e = exp_pix.pop_front();
                chk("cfg_num", 64'(cfg_num), 64'(e[29:24]));
                chk("cfg_data", 64'(cfg_data), 64'(e[23:0]));
            end
        end
        pix_pend = cfg_start && !rst;
        if (ws_start) begin
            n_starts++;
            if (exp_gnt.size() == 0) begin
                chk("start_unexpected", 1, 0);
            end else begin
                g = exp_gnt.pop_front();
                chk("gnt_a", 64'(gnt_a), 64'(!g));
                chk("gnt_b", 64'(gnt_b), 64'(g));
            end
        end
        if (gnt_a && gnt_b) overlap_seen = 1'b1;
        if (wdog_err) wdog_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; cfg_start = 1'b0; tx_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_start(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (ws_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("start_seen", 64'(ok), 1);
        tick();   // ws2812_start cycle is START; the next one is FEED
    endtask

    // Issue n pixel requests; tx_done rides along with request tx_at
    task automatic feed(input bit src_b, input int n, input int tx_at);
        for (int k = 0; k < n; k++) begin
            cfg_start = 1'b1;
            tx_done   = (k == tx_at);
            exp_pix.push_back({6'(k), src_b ? pat_b(6'(k)) : pat_a(6'(k))});
            tick();
            cfg_start = 1'b0;
            tx_done   = 1'b0;
            tick();
            tick();
        end
    endtask

    // Pulse tx_done and measure how long busy stays high afterwards
    task automatic end_frame();
        int cnt = 0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        while (busy && cnt < int'(GAP_CYC) + 50) begin
            cnt++;
            tick();
        end
        chk("gap_len", 64'(cnt), 64'(GAP_CYC));
        chk("gnt_release", 64'({gnt_a, gnt_b}), 0);
    endtask

    initial begin
        #(50000 * 10);
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int s0;

        // Reset state
        do_reset();
        chk("rst_outputs", 64'({gnt_a, gnt_b, pix_idx, ws_start, cfg_num, cfg_data, wdog_err}), 0);
        chk("rst_busy", 64'(busy), 0);

        // Single source A frame; request drops mid-frame; tx_done with pixel 10 is ignored
        exp_gnt.push_back(1'b0);
        req_a = 1'b1;
        wait_start(20);
        req_a = 1'b0;
        feed(1'b0, NUM_LED, 10);
        repeat (300) tick();
        chk("drain_hold_busy", 64'(busy), 1);
        // cfg_start in DRAIN leaves the last pixel on the outputs
        exp_pix.push_back({6'(NUM_LED - 1), pat_a(6'(NUM_LED - 1))});
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        tick();
        end_frame();

        // A one-cycle request gone by ARB returns to IDLE without a frame
        s0 = n_starts;
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        repeat (10) tick();
        chk("pulse_no_start", 64'(n_starts), 64'(s0));
        chk("pulse_idle", 64'(busy), 0);

        // Both requests held: A, B, A
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        for (int f = 0; f < 3; f++) begin
            exp_gnt.push_back(f == 1);
            wait_start(int'(GAP_CYC) + 50);
            if (f == 2) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            feed(f == 1, NUM_LED, -1);
            if (f < 2) begin
                tx_done = 1'b1;
                tick();
                tx_done = 1'b0;
            end else begin
                end_frame();
            end
        end

        // Source B request withdrawn as soon as the frame is granted
        do_reset();
        exp_gnt.push_back(1'b1);
        req_b = 1'b1;
        wait_start(20);
        req_b = 1'b0;
        feed(1'b1, NUM_LED, -1);
        end_frame();

        // Reset after the 20th pixel, then a fresh frame restarts at pixel 0
        do_reset();
        exp_gnt.push_back(1'b0);
        req_a = 1'b1;
        wait_start(20);
        req_a = 1'b0;
        feed(1'b0, 20, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_outputs", 64'({gnt_a, gnt_b, pix_idx, ws_start, cfg_num, cfg_data, wdog_err}), 0);
        chk("midrst_busy", 64'(busy), 0);
        s0 = n_starts;
        repeat (5) tick();
        chk("midrst_no_start", 64'(n_starts), 64'(s0));
        exp_gnt.push_back(1'b0);
        req_a = 1'b1;
        wait_start(20);
        req_a = 1'b0;
        feed(1'b0, NUM_LED, -1);
        end_frame();

        repeat (3) tick();
        chk("queues_empty", 64'(exp_pix.size() + exp_gnt.size()), 0);
        chk("gnt_overlap", 64'(overlap_seen), 0);
        chk("wdog_quiet", 64'(wdog_seen), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
